// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA text-mode character buffer.
package vga_pkg;

   localparam int TEXT_BUF_DEPTH = 256;
   localparam int ADDR_W         = 8;
   localparam int CHAR_W         = 7;

   localparam logic [CHAR_W-1:0] CHAR_SPACE = 7'h20;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } tb_state_e;

   typedef enum logic {
      GNT_A,
      GNT_B
   } gnt_e;

endpackage

// File: rtl/char_buf_ram.sv
// 256 x 7 simple dual-port character store with registered read.
module char_buf_ram
   import vga_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [CHAR_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [CHAR_W-1:0] rdata
);

   logic [CHAR_W-1:0] mem_q [TEXT_BUF_DEPTH];
   logic [CHAR_W-1:0] rd_data_d;
   logic [CHAR_W-1:0] rd_data_q;

   always_comb begin
      rd_data_d = mem_q[raddr];
   end

   // Storage has no reset; the clear sequencer initialises it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rdata = rd_data_q;

endmodule

// File: rtl/text_buf_arbiter.sv
// Write-port arbiter for the text buffer: clear sequencer plus two
// round-robin requesters, all writes confined to vertical blanking.
module text_buf_arbiter
   import vga_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              vblnk,
   input  logic              req_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [CHAR_W-1:0] data_a,
   output logic              ack_a,
   input  logic              req_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [CHAR_W-1:0] data_b,
   output logic              ack_b,
   input  logic              clr,
   input  logic [ADDR_W-1:0] char_xy,
   output logic [CHAR_W-1:0] char_code,
   output logic              busy,
   output logic              clr_done
);

   tb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   gnt_e              last_q, last_d;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [CHAR_W-1:0] wdata;
   logic              gnt_a;
   logic              gnt_b;

   // Reset parks the FSM in CLEAR so release starts the full clear;
   // everything is gated off while rst is held.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      we       = 1'b0;
      waddr    = cnt_q;
      wdata    = CHAR_SPACE;
      ack_a    = 1'b0;
      ack_b    = 1'b0;
      clr_done = 1'b0;
      gnt_a    = 1'b0;
      gnt_b    = 1'b0;
      busy     = (state_q == ST_CLEAR) && !rst;
      if (!rst) begin
         unique case (state_q)
            ST_CLEAR: begin
               if (vblnk) begin
                  we = 1'b1;
                  if (cnt_q == 8'hFF) begin
                     clr_done = 1'b1;
                     state_d  = ST_IDLE;
                     cnt_d    = '0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
            ST_IDLE: begin
               if (clr) begin
                  state_d = ST_CLEAR;
                  cnt_d   = '0;
               end else if (vblnk) begin
                  gnt_a = req_a && (!req_b || last_q == GNT_B);
                  gnt_b = req_b && !gnt_a;
                  unique case (1'b1)
                     gnt_a: begin
                        we     = 1'b1;
                        waddr  = addr_a;
                        wdata  = data_a;
                        ack_a  = 1'b1;
                        last_d = GNT_A;
                     end
                     gnt_b: begin
                        we     = 1'b1;
                        waddr  = addr_b;
                        wdata  = data_b;
                        ack_b  = 1'b1;
                        last_d = GNT_B;
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         last_q  <= GNT_B;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   char_buf_ram u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (char_xy),
      .rdata (char_code)
   );

endmodule

// File: tb/tb_text_buf_arbiter.sv
// Directed self-checking bench for text_buf_arbiter.
module tb_text_buf_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vblnk = 1'b0;
   logic       req_a = 1'b0;
   logic [7:0] addr_a = '0;
   logic [6:0] data_a = '0;
   logic       ack_a;
   logic       req_b = 1'b0;
   logic [7:0] addr_b = '0;
   logic [6:0] data_b = '0;
   logic       ack_b;
   logic       clr = 1'b0;
   logic [7:0] char_xy = '0;
   logic [6:0] char_code;
   logic       busy;
   logic       clr_done;

   int checks = 0;
   int errors = 0;
   int nw, nb, nd, da;

   always #5 clk = ~clk;

   text_buf_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .vblnk     (vblnk),
      .req_a     (req_a),
      .addr_a    (addr_a),
      .data_a    (data_a),
      .ack_a     (ack_a),
      .req_b     (req_b),
      .addr_b    (addr_b),
      .data_b    (data_b),
      .ack_b     (ack_b),
      .clr       (clr),
      .char_xy   (char_xy),
      .char_code (char_code),
      .busy      (busy),
      .clr_done  (clr_done)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs a clear from the current cycle; period 0 keeps vblnk high,
   // otherwise vblnk toggles every period cycles. clr pulses at clr_at.
   task automatic run_clear(input int max, input int period,
                            input int clr_at, output int o_nw,
                            output int o_nb, output int o_nd,
                            output int o_da);
      o_nw = 0; o_nb = 0; o_nd = 0; o_da = 0;
      for (int k = 0; k < max; k++) begin
         if (k > 0) @(negedge clk);
         vblnk = (period == 0) ? 1'b1 : (((k / period) % 2) == 0);
         clr   = (k == clr_at);
         #1;
         if (!busy) break;
         o_nb++;
         if (vblnk) o_nw++;
         if (clr_done) begin
            o_nd++;
            o_da = o_nw;
         end
      end
      clr = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [6:0] exp,
                     input string tag);
      @(negedge clk);
      char_xy = a;
      @(negedge clk);
      #1;
      check(tag, char_code, exp);
   endtask

   initial begin
      // reset state
      rst = 1'b1; vblnk = 1'b1; req_a = 1'b1; req_b = 1'b1; clr = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_ack_a", ack_a, 0);
      check("rst_ack_b", ack_b, 0);
      check("rst_clr_done", clr_done, 0);
      check("rst_char_code", char_code, 0);
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0; clr = 1'b0; rst = 1'b0;

      // automatic clear after reset release
      run_clear(400, 0, -1, nw, nb, nd, da);
      check("init_busy_cycles", nb, 256);
      check("init_writes", nw, 256);
      check("init_done_count", nd, 1);
      check("init_done_at", da, 256);

      @(negedge clk);
      char_xy = 8'd0;
      for (int i = 1; i <= 256; i++) begin
         @(negedge clk);
         #1;
         if (char_code !== 7'h20) check("init_read", char_code, 7'h20);
         else checks++;
         char_xy = i[7:0];
      end

      // tie: A wins first after reset, then alternate
      @(negedge clk);
      vblnk = 1'b1;
      req_a = 1'b1; addr_a = 8'h01; data_a = 7'h11;
      req_b = 1'b1; addr_b = 8'h02; data_b = 7'h22;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         check("rr_ack_a", ack_a, (i % 2) == 0);
         check("rr_ack_b", ack_b, (i % 2) == 1);
         check("rr_busy", busy, 0);
      end
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0;
      rd(8'h01, 7'h11, "rr_read_a");
      rd(8'h02, 7'h22, "rr_read_b");

      // single write and readback
      @(negedge clk);
      req_a = 1'b1; addr_a = 8'h12; data_a = 7'h41;
      #1;
      check("wr_ack_a", ack_a, 1);
      check("wr_ack_b", ack_b, 0);
      @(negedge clk);
      req_a = 1'b0; char_xy = 8'h12;
      @(negedge clk);
      #1;
      check("wr_read", char_code, 7'h41);

      // same-cycle read/write returns old data
      req_a = 1'b1; data_a = 7'h42;
      #1;
      check("rw_ack_a", ack_a, 1);
      @(negedge clk);
      req_a = 1'b0;
      #1;
      check("rw_old", char_code, 7'h41);
      @(negedge clk);
      #1;
      check("rw_new", char_code, 7'h42);

      // back-to-back from one requester
      req_a = 1'b1; addr_a = 8'h60;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         data_a = 7'h70 + i[6:0];
         #1;
         check("b2b_ack_a", ack_a, 1);
      end
      @(negedge clk);
      req_a = 1'b0;
      rd(8'h60, 7'h72, "b2b_read");

      // request held outside blanking waits
      @(negedge clk);
      vblnk = 1'b0;
      req_b = 1'b1; addr_b = 8'h40; data_b = 7'h5A;
      nw = 0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (ack_b) nw++;
      end
      check("vb0_no_ack", nw, 0);
      @(negedge clk);
      vblnk = 1'b1;
      #1;
      check("vb1_ack_b", ack_b, 1);
      @(negedge clk);
      req_b = 1'b0;
      rd(8'h40, 7'h5A, "vb_read");

      // clr beats a request; paused clear with a second clr ignored
      @(negedge clk);
      vblnk = 1'b1; clr = 1'b1;
      req_a = 1'b1; addr_a = 8'h50; data_a = 7'h7F;
      #1;
      check("clr_ack_a", ack_a, 0);
      check("clr_busy0", busy, 0);
      @(negedge clk);
      clr = 1'b0; req_a = 1'b0;
      run_clear(2000, 100, 50, nw, nb, nd, da);
      check("pause_writes", nw, 256);
      check("pause_busy_cycles", nb, 456);
      check("pause_done_count", nd, 1);
      check("pause_done_at", da, 256);
      rd(8'h50, 7'h20, "pause_read_50");
      rd(8'h12, 7'h20, "pause_read_12");

      // reset mid-clear restarts from zero
      @(negedge clk);
      vblnk = 1'b1; clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      run_clear(100, 0, -1, nw, nb, nd, da);
      check("abort_writes", nw, 100);
      check("abort_done", nd, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("abort_rst_busy", busy, 0);
      check("abort_rst_done", clr_done, 0);
      check("abort_rst_code", char_code, 0);
      @(negedge clk);
      rst = 1'b0;
      run_clear(400, 0, -1, nw, nb, nd, da);
      check("restart_busy_cycles", nb, 256);
      check("restart_done_count", nd, 1);
      check("restart_done_at", da, 256);
      rd(8'hFF, 7'h20, "restart_read_ff");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
